kernel_window_buffer: RTL and testbench

Upstream neighbour of `median_processing`. It accepts a raster-scan pixel stream on an AXI4-Stream slave, holds the last KERNEL_SIZE-1 image lines in line buffers, and assembles a KERNEL_SIZE×KERNEL_SIZE sliding window. For every accepted pixel that completes a fully in-image window, it emits that window with a valid pulse and a start-of-frame flag, ready for direct connection to `median_processing` inputs. The output image is (IMAGE_WIDTH-K+1)×(IMAGE_HEIGHT-K+1); there is no border padding.

---
 rtl/median_pkg.sv | 19 +
 rtl/line_buffer.sv | 28 ++
 rtl/kernel_window_buffer.sv | 155 +++++++++++++++
 tb/tb_kernel_window_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types and defaults for the kernel window buffer and median_processing.
package median_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int KERNEL_SIZE_DEF  = 5;
  localparam int IMAGE_WIDTH_DEF  = 10;
  localparam int IMAGE_HEIGHT_DEF = 8;

  typedef logic [DATA_WIDTH_DEF-1:0] pixel_t;

  // Square neighbourhood handed to the median stage; [0][0] is the oldest pixel.
  typedef logic [0:KERNEL_SIZE_DEF-1][0:KERNEL_SIZE_DEF-1][DATA_WIDTH_DEF-1:0] kernel_t;

  // Index width for a table of the given depth (never narrower than one bit).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of delay: single-port memory indexed by column, the old word
// is read out on the same edge that overwrites it.
module line_buffer
  import median_pkg::*;
#(
  parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int  DEPTH      = IMAGE_WIDTH_DEF,
  localparam int AW         = idx_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  // Write the new pixel; the asynchronous read below still sees the previous line.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/kernel_window_buffer.sv
// Raster-scan pixel stream in, KxK sliding window out (no border padding).
// K-1 line buffers supply the upper rows of each new window column; the window
// itself is a KxK register array that shifts left on every accepted pixel.
module kernel_window_buffer
  import median_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF,
  parameter int IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
  parameter int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] o_image_kernel_buffer [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
  output logic                  o_image_data_valid,
  output logic                  o_start_of_frame,
  output logic                  o_frame_err
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = idx_w(IMAGE_WIDTH);
  localparam int RW = idx_w(IMAGE_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] COL_FULL = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FULL = RW'(K - 1);

  logic                  tready_q;
  logic [CW-1:0]         col_q, col_d, cur_col;
  logic [RW-1:0]         row_q, row_d, cur_row;
  logic                  vld_q, vld_d;
  logic                  sof_q, sof_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  at_col_last;

  logic [DATA_WIDTH-1:0] lb_din  [0:K-2];
  logic [DATA_WIDTH-1:0] lb_dout [0:K-2];
  logic [DATA_WIDTH-1:0] new_col [0:K-1];
  logic [DATA_WIDTH-1:0] win_q   [0:K-1][0:K-1];
  logic [DATA_WIDTH-1:0] win_d   [0:K-1][0:K-1];

  assign accept = s_axis_tvalid && tready_q;

  // A start-of-frame beat is always pixel (0,0), whatever the counters say.
  assign cur_col     = s_axis_tuser ? '0 : col_q;
  assign cur_row     = s_axis_tuser ? '0 : row_q;
  assign at_col_last = (cur_col == COL_LAST);

  // Line-buffer chain: each buffer takes what the one above it just released.
  always_comb begin
    lb_din[0] = s_axis_tdata;
    for (int g = 1; g < K - 1; g++) begin
      lb_din[g] = lb_dout[g-1];
    end
  end

  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMAGE_WIDTH)
    ) u_lb (
      .clk_i  (i_clk),
      .we_i   (accept),
      .addr_i (cur_col),
      .din_i  (lb_din[g]),
      .dout_o (lb_dout[g])
    );
  end

  // New rightmost window column, oldest line at the top, live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = lb_dout[K-2-r];
    end
    new_col[K-1] = s_axis_tdata;
  end

  // Position tracking, window pulses and line-length error on each accepted beat.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    vld_d = 1'b0;
    sof_d = 1'b0;
    err_d = err_q;
    if (accept) begin
      col_d = at_col_last ? '0 : cur_col + 1'b1;
      row_d = cur_row;
      if (at_col_last) begin
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end
      vld_d = (cur_row >= ROW_FULL) && (cur_col >= COL_FULL);
      sof_d = (cur_row == ROW_FULL) && (cur_col == COL_FULL);
      err_d = (s_axis_tuser ? 1'b0 : err_q) | (s_axis_tlast != at_col_last);
    end
  end

  // Window shifts left by one column per accepted beat and holds otherwise.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K-1] = new_col[r];
      end
    end
  end

  // Control state; ready rises on the first clock after reset release.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      tready_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      vld_q    <= 1'b0;
      sof_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      col_q    <= col_d;
      row_q    <= row_d;
      vld_q    <= vld_d;
      sof_q    <= sof_d;
      err_q    <= err_d;
    end
  end

  // Window registers clear on reset so nothing stale is ever presented.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      win_q <= win_d;
    end
  end

  assign s_axis_tready         = tready_q;
  assign o_image_kernel_buffer = win_q;
  assign o_image_data_valid    = vld_q;
  assign o_start_of_frame      = sof_q;
  assign o_frame_err           = err_q;

endmodule

// File: tb/tb_kernel_window_buffer.sv
// Directed bench for kernel_window_buffer: the driver pushes the window it
// expects for each accepted beat, an independent monitor pops and compares.
module tb_kernel_window_buffer;

  localparam int K = 5;
  localparam int W = 10;
  localparam int H = 8;

  typedef struct packed {
    logic [K*K-1:0][7:0] w;
    logic                sof;
    int                  due;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_aresetn = 1'b1;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tuser = 1'b0;
  logic       s_axis_tlast = 1'b0;
  logic [7:0] win [0:K-1][0:K-1];
  logic       o_image_data_valid;
  logic       o_start_of_frame;
  logic       o_frame_err;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   sof_cnt = 0;
  exp_t q[$];

  kernel_window_buffer #(
    .DATA_WIDTH   (8),
    .KERNEL_SIZE  (K),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .i_clk                 (i_clk),
    .i_aresetn             (i_aresetn),
    .s_axis_tdata          (s_axis_tdata),
    .s_axis_tvalid         (s_axis_tvalid),
    .s_axis_tready         (s_axis_tready),
    .s_axis_tuser          (s_axis_tuser),
    .s_axis_tlast          (s_axis_tlast),
    .o_image_kernel_buffer (win),
    .o_image_data_valid    (o_image_data_valid),
    .o_start_of_frame      (o_start_of_frame),
    .o_frame_err           (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: every presented window must match the oldest expectation, on time.
  exp_t me;
  int   nb, fi, fj;
  always @(negedge i_clk) begin
    if (o_image_data_valid) begin
      pulse_cnt++;
      if (o_start_of_frame) sof_cnt++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_window cyc=%0d got=valid required=no window", cyc);
      end else begin
        me = q.pop_front();
        if (me.due != cyc) begin
          bad++;
          $display("FAIL window_latency got_cycle=%0d required_cycle=%0d", cyc, me.due);
        end
        nb = 0; fi = 0; fj = 0;
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            if (win[i][j] !== me.w[i*K+j]) begin
              if (nb == 0) begin fi = i; fj = j; end
              nb++;
            end
          end
        end
        total++;
        if (nb != 0) begin
          bad++;
          $display("FAIL window_data cyc=%0d [%0d][%0d] got=%0d required=%0d (%0d cells differ)",
                   cyc, fi, fj, win[fi][fj], me.w[fi*K+fj], nb);
        end
        total++;
        if (o_start_of_frame !== me.sof) begin
          bad++;
          $display("FAIL window_sof cyc=%0d got=%0b required=%0b", cyc, o_start_of_frame, me.sof);
        end
      end
    end else begin
      if (o_start_of_frame) begin
        total++; bad++;
        $display("FAIL sof_without_valid cyc=%0d got=1 required=0", cyc);
      end
      if (q.size() > 0 && q[0].due <= cyc) begin
        me = q.pop_front();
        total++; bad++;
        $display("FAIL missing_window cyc=%0d got=no valid required=window due at %0d", cyc, me.due);
      end
    end
  end

  task automatic check1(input string nm, input logic got, input logic req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0b required=%0b", nm, got, req);
    end
  endtask

  task automatic check_win_zero(input string nm);
    int nz = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        if (win[i][j] !== 8'd0) nz++;
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL %s got=%0d nonzero cells required=0", nm, nz);
    end
  endtask

  // One beat, accepted on the next rising edge; pushes its window if it completes one.
  task automatic beat(input logic [7:0] d, input logic u, input logic l,
                      input bit want, input exp_t e);
    int guard = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
    end
    if (!s_axis_tready) begin
      total++; bad++;
      $display("FAIL tready_stuck got=0 required=1");
    end
    @(posedge i_clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    if (want) begin
      e.due = cyc;
      q.push_back(e);
    end
  endtask

  // Frame of pixel = base + row*10 + col, first nbeats beats only.
  task automatic send_frame(input int base, input bit gaps, input int err_r,
                            input int err_c, input int nbeats);
    exp_t e;
    int   n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < nbeats) begin
          if (gaps) begin
            repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
          end
          e = '0;
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              e.w[i*K+j] = 8'(base + (r - (K-1) + i) * W + (c - (K-1) + j));
          e.sof = (r == K-1) && (c == K-1);
          beat(8'(base + r * W + c), (r == 0 && c == 0),
               (c == W-1) || (r == err_r && c == err_c),
               (r >= K-1) && (c >= K-1), e);
          if (r == err_r && c == err_c) check1("frame_err_set", o_frame_err, 1'b1);
          n++;
        end
      end
    end
  endtask

  task automatic frame_counts(input string nm, input int p0, input int s0,
                              input int ep, input int es);
    @(negedge i_clk); #1;
    total++;
    if (pulse_cnt - p0 != ep) begin
      bad++;
      $display("FAIL %s_pulses got=%0d required=%0d", nm, pulse_cnt - p0, ep);
    end
    total++;
    if (sof_cnt - s0 != es) begin
      bad++;
      $display("FAIL %s_sof_count got=%0d required=%0d", nm, sof_cnt - s0, es);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=no finish required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, s0;
    // Power-on reset
    #1 i_aresetn = 1'b0;
    #2;
    check1("reset_tready", s_axis_tready, 1'b0);
    check1("reset_valid", o_image_data_valid, 1'b0);
    check1("reset_sof", o_start_of_frame, 1'b0);
    check1("reset_err", o_frame_err, 1'b0);
    check_win_zero("reset_window");
    #14 i_aresetn = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    check1("tready_after_reset", s_axis_tready, 1'b1);

    // Ramp frame, continuous
    p0 = pulse_cnt; s0 = sof_cnt;
    send_frame(0, 1'b0, -1, -1, W*H);
    frame_counts("ramp", p0, s0, 24, 1);
    check1("ramp_no_err", o_frame_err, 1'b0);
    repeat (3) begin @(posedge i_clk); #1; end
    total++;
    if (win[K-1][K-1] !== 8'd79 || win[0][0] !== 8'd35) begin
      bad++;
      $display("FAIL window_hold got=%0d/%0d required=79/35", win[K-1][K-1], win[0][0]);
    end
    check1("idle_no_valid", o_image_data_valid, 1'b0);

    // Same frame with random gaps
    p0 = pulse_cnt; s0 = sof_cnt;
    send_frame(0, 1'b1, -1, -1, W*H);
    frame_counts("gaps", p0, s0, 24, 1);

    // Two frames back to back
    p0 = pulse_cnt; s0 = sof_cnt;
    send_frame(0, 1'b0, -1, -1, W*H);
    send_frame(100, 1'b0, -1, -1, W*H);
    frame_counts("two_frames", p0, s0, 48, 2);

    // Reset during row 5, then a clean frame
    send_frame(0, 1'b0, -1, -1, 5*W + 3);
    #2 i_aresetn = 1'b0;
    #1;
    check1("midreset_tready", s_axis_tready, 1'b0);
    check1("midreset_valid", o_image_data_valid, 1'b0);
    check1("midreset_sof", o_start_of_frame, 1'b0);
    check_win_zero("midreset_window");
    repeat (2) @(posedge i_clk);
    #3 i_aresetn = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    p0 = pulse_cnt; s0 = sof_cnt;
    send_frame(0, 1'b0, -1, -1, W*H);
    frame_counts("after_reset", p0, s0, 24, 1);

    // Early tlast at (2,7): sticky error, counting unaffected
    p0 = pulse_cnt; s0 = sof_cnt;
    send_frame(0, 1'b0, 2, 7, W*H);
    frame_counts("tlast_err", p0, s0, 24, 1);
    check1("frame_err_held", o_frame_err, 1'b1);
    send_frame(30, 1'b0, -1, -1, 1);
    check1("frame_err_cleared", o_frame_err, 1'b0);

    // Mid-frame tuser at (6,3)
    p0 = pulse_cnt; s0 = sof_cnt;
    send_frame(0, 1'b0, -1, -1, 6*W + 3);
    send_frame(50, 1'b0, -1, -1, W*H);
    frame_counts("resync", p0, s0, 36, 2);

    repeat (3) begin @(posedge i_clk); #1; end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending_windows got=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
